// File: rtl/hpdmc_defs.sv
// hpdmc_defs: shared widths, CTI encodings and arbiter state type for HPDMC port sharing
package hpdmc_defs;
    localparam int ADR_W = 32;
    localparam int DAT_W = 64;
    localparam int SEL_W = 8;
    localparam int CTI_W = 3;
    localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
    localparam logic [CTI_W-1:0] CTI_END     = 3'b111;
    typedef enum logic {ST_IDLE, ST_GRANTED} arb_state_e;
endpackage

// File: rtl/hpdmc_rr_pick.sv
// hpdmc_rr_pick: combinational round-robin picker searching from last+1 with wrap
module hpdmc_rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [1:0]   last_i,
    output logic         any_o,
    output logic [1:0]   winner_o
);
    logic [1:0] idx;
    // Walk candidates from farthest to nearest so the closest requester after last wins
    always_comb begin
        winner_o = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = 2'((int'(last_i) + 1 + i) % N);
            if (req_i[idx]) winner_o = idx;
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/hpdmc_arbiter.sv
// hpdmc_arbiter: round-robin WISHBONE arbiter sharing the HPDMC memory port, grant held per bus cycle
module hpdmc_arbiter
    import hpdmc_defs::*;
#(
    parameter int nmasters = 3
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [ADR_W*nmasters-1:0] m_adr_i,
    input  logic [CTI_W*nmasters-1:0] m_cti_i,
    input  logic [DAT_W*nmasters-1:0] m_dat_i,
    input  logic [SEL_W*nmasters-1:0] m_sel_i,
    input  logic [nmasters-1:0]       m_cyc_i,
    input  logic [nmasters-1:0]       m_stb_i,
    input  logic [nmasters-1:0]       m_we_i,
    input  logic [nmasters-1:0]       m_nextadr_valid,
    input  logic [ADR_W*nmasters-1:0] m_nextadr,
    output logic [DAT_W-1:0]          m_dat_o,
    output logic [nmasters-1:0]       m_ack_o,
    output logic [ADR_W-1:0]          wb_adr_o,
    output logic [CTI_W-1:0]          wb_cti_o,
    output logic [DAT_W-1:0]          wb_dat_o,
    output logic [SEL_W-1:0]          wb_sel_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic                      wb_nextadr_valid_o,
    output logic [ADR_W-1:0]          wb_nextadr_o,
    input  logic [DAT_W-1:0]          wb_dat_i,
    input  logic                      wb_ack_i,
    output logic                      gnt_valid_o,
    output logic [1:0]                gnt_o
);
    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d, last_q, last_d, winner;
    logic any, sel_cyc, sel_stb, sel_nav;

    hpdmc_rr_pick #(.N(nmasters)) u_pick (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .any_o   (any),
        .winner_o(winner)
    );

    // Grant registers; reset makes master 0 the first round-robin winner
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= 2'(nmasters - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Re-arbitrate only when idle or when the owner has dropped cyc; the owner sits last in the search
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        if (state_q == ST_IDLE || !m_cyc_i[gnt_q]) begin
            state_d = any ? ST_GRANTED : ST_IDLE;
            gnt_d   = any ? winner : gnt_q;
            last_d  = any ? winner : last_q;
        end
    end

    // Route the granted slice to the memory port and its ack back to the owner only
    always_comb begin
        wb_adr_o     = '0;
        wb_cti_o     = '0;
        wb_dat_o     = '0;
        wb_sel_o     = '0;
        wb_we_o      = 1'b0;
        wb_nextadr_o = '0;
        sel_cyc      = 1'b0;
        sel_stb      = 1'b0;
        sel_nav      = 1'b0;
        m_ack_o      = '0;
        for (int k = 0; k < nmasters; k++) begin
            if (gnt_q == 2'(k)) begin
                wb_adr_o     = m_adr_i[ADR_W*k +: ADR_W];
                wb_cti_o     = m_cti_i[CTI_W*k +: CTI_W];
                wb_dat_o     = m_dat_i[DAT_W*k +: DAT_W];
                wb_sel_o     = m_sel_i[SEL_W*k +: SEL_W];
                wb_we_o      = m_we_i[k];
                wb_nextadr_o = m_nextadr[ADR_W*k +: ADR_W];
                sel_cyc      = m_cyc_i[k];
                sel_stb      = m_stb_i[k];
                sel_nav      = m_nextadr_valid[k];
                m_ack_o[k]   = wb_ack_i & gnt_valid_o & m_cyc_i[k];
            end
        end
    end

    assign gnt_valid_o        = state_q == ST_GRANTED;
    assign gnt_o              = gnt_q;
    assign wb_cyc_o           = gnt_valid_o & sel_cyc;
    assign wb_stb_o           = wb_cyc_o & sel_stb;
    assign wb_nextadr_valid_o = gnt_valid_o & sel_nav;
    assign m_dat_o            = wb_dat_i;
endmodule

// File: tb/tb_hpdmc_arbiter.sv
// tb_hpdmc_arbiter: scoreboard bench for the HPDMC round-robin arbiter
module tb_hpdmc_arbiter;
    import hpdmc_defs::*;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [95:0]  m_adr_i = '0;
    logic [8:0]   m_cti_i = '0;
    logic [191:0] m_dat_i = '0;
    logic [23:0]  m_sel_i = '1;
    logic [2:0]   m_cyc_i = '0;
    logic [2:0]   m_stb_i = '1;
    logic [2:0]   m_we_i = '0;
    logic [2:0]   m_nextadr_valid = '0;
    logic [95:0]  m_nextadr = '0;
    logic [63:0]  m_dat_o;
    logic [2:0]   m_ack_o;
    logic [31:0]  wb_adr_o;
    logic [2:0]   wb_cti_o;
    logic [63:0]  wb_dat_o;
    logic [7:0]   wb_sel_o;
    logic         wb_cyc_o, wb_stb_o, wb_we_o, wb_nextadr_valid_o;
    logic [31:0]  wb_nextadr_o;
    logic [63:0]  wb_dat_i = '0;
    logic         wb_ack_i = 1'b0;
    logic         gnt_valid_o;
    logic [1:0]   gnt_o;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [2:0]  ack;
        logic [31:0] adr;
        logic [2:0]  cti;
    } beat_t;

    beat_t sb[$];
    beat_t e;
    int checks = 0;
    int errors = 0;

    hpdmc_arbiter #(.nmasters(3)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_adr_i(m_adr_i), .m_cti_i(m_cti_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_nextadr_valid(m_nextadr_valid), .m_nextadr(m_nextadr),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .wb_adr_o(wb_adr_o), .wb_cti_o(wb_cti_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_nextadr_valid_o(wb_nextadr_valid_o), .wb_nextadr_o(wb_nextadr_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .gnt_valid_o(gnt_valid_o), .gnt_o(gnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Owner k runs a 4-beat INCR burst; each acked beat's expected routing goes to the scoreboard
    task automatic burst(input int k, input logic [31:0] base);
        logic [2:0] cti;
        for (int i = 0; i < 4; i++) begin
            cti = (i == 3) ? CTI_END : CTI_INCR;
            m_adr_i[32*k +: 32] = base + 32'(8 * i);
            m_cti_i[3*k +: 3] = cti;
            wb_ack_i = 1'b1;
            sb.push_back('{gnt: 2'(k), ack: 3'(1 << k), adr: base + 32'(8 * i), cti: cti});
            tick;
        end
        wb_ack_i = 1'b0;
    endtask

    // Monitor: every beat the memory acks is checked against the oldest expected beat
    always @(negedge sys_clk) begin
        if (!sys_rst && wb_cyc_o && wb_ack_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected ack gnt=%0d m_ack=%b adr=%h", gnt_o, m_ack_o, wb_adr_o);
            end else begin
                e = sb.pop_front();
                if (gnt_o !== e.gnt || m_ack_o !== e.ack || wb_adr_o !== e.adr || wb_cti_o !== e.cti || wb_stb_o !== 1'b1) begin
                    errors++;
                    $display("FAIL beat: got gnt=%0d ack=%b adr=%h cti=%b stb=%b expected gnt=%0d ack=%b adr=%h cti=%b stb=1",
                             gnt_o, m_ack_o, wb_adr_o, wb_cti_o, wb_stb_o, e.gnt, e.ack, e.adr, e.cti);
                end
            end
        end
    end

    initial begin
        #2;
        check("rst_gnt_valid", 64'(gnt_valid_o), 64'd0);
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_ack", 64'(m_ack_o), 64'd0);
        tick;
        tick;
        sys_rst = 1'b0;
        tick;
        check("idle_gnt_valid", 64'(gnt_valid_o), 64'd0);
        check("idle_cyc", 64'(wb_cyc_o), 64'd0);
        wb_ack_i = 1'b1;
        wb_dat_i = 64'hDEADBEEF_01234567;
        #1;
        check("idle_stray_ack", 64'(m_ack_o), 64'd0);
        check("dat_broadcast", m_dat_o, 64'hDEADBEEF_01234567);
        tick;
        wb_ack_i = 1'b0;
        m_cyc_i = 3'b111;
        tick;
        check("first_gnt", 64'(gnt_o), 64'd0);
        check("first_gnt_valid", 64'(gnt_valid_o), 64'd1);
        for (int r = 0; r < 6; r++) begin
            int k;
            k = r % 3;
            check("rr_gnt", 64'(gnt_o), 64'(k));
            check("rr_cyc", 64'(wb_cyc_o), 64'd1);
            if (r == 2) begin
                m_nextadr[64 +: 32] = 32'h0000_1000;
                m_nextadr[0 +: 32] = 32'hFFFF_0000;
                m_nextadr_valid = 3'b101;
                #1;
                check("pred_adr", 64'(wb_nextadr_o), 64'h1000);
                check("pred_valid", 64'(wb_nextadr_valid_o), 64'd1);
                m_nextadr_valid = 3'b001;
                #1;
                check("pred_other_valid", 64'(wb_nextadr_valid_o), 64'd0);
                m_nextadr_valid = 3'b000;
            end
            burst(k, 32'h0100_0000 * 32'(k + 1) + 32'h40 * 32'(r));
            m_cyc_i[k] = 1'b0;
            #1;
            check("bubble_cyc", 64'(wb_cyc_o), 64'd0);
            tick;
            m_cyc_i[k] = 1'b1;
        end
        check("pre_rst_gnt", 64'(gnt_o), 64'd0);
        m_adr_i[0 +: 32] = 32'h0000_2000;
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_cyc", 64'(wb_cyc_o), 64'd0);
        check("async_gnt_valid", 64'(gnt_valid_o), 64'd0);
        m_cyc_i = 3'b000;
        tick;
        sys_rst = 1'b0;
        m_cyc_i = 3'b100;
        check("post_rst_wait", 64'(wb_cyc_o), 64'd0);
        tick;
        check("post_rst_gnt", 64'(gnt_o), 64'd2);
        check("post_rst_cyc", 64'(wb_cyc_o), 64'd1);
        burst(2, 32'h0000_3000);
        m_cyc_i = 3'b000;
        tick;
        check("final_idle", 64'(gnt_valid_o), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
